// File: rtl/cpu_bus_mem.sv
// Memory and bus model for the 6502 core: mirrored RAM, loadable ROM, open-bus latch,
// optional reset-vector override and a bus-trace FIFO capturing every CPU access.
module cpu_bus_mem #(
  parameter int unsigned RAM_AW   = 11,
  parameter logic [15:0] RAM_TOP  = 16'h1FFF,
  parameter logic [15:0] ROM_BASE = 16'h8000,
  parameter int unsigned ROM_AW   = 15,
  parameter bit          VEC_OVR  = 1'b1,
  parameter logic [15:0] RST_VEC  = 16'h8000,
  parameter int unsigned TRC_AW   = 4
) (
  input  logic              clk_ph2,
  input  logic              rst,
  input  logic [15:0]       Addr_bus,
  input  logic [7:0]        Data_bus_out,
  input  logic              R_nW,
  output logic [7:0]        Data_bus_in,
  input  logic              prog_we,
  input  logic [ROM_AW-1:0] prog_addr,
  input  logic [7:0]        prog_data,
  input  logic              trc_en,
  input  logic              trc_rd,
  output logic              trc_valid,
  output logic [24:0]       trc_data,
  output logic [7:0]        trc_ovf_cnt,
  output logic              rom_wr_err
);

  localparam int unsigned TrcDepth = 2 ** TRC_AW;
  localparam logic [TRC_AW:0] PtrOne = 1;

  logic [7:0]  ram [2 ** RAM_AW];
  logic [7:0]  rom [2 ** ROM_AW];
  logic [24:0] trc_mem [TrcDepth];

  logic [7:0]      ob_q;
  logic            rom_wr_err_q;
  logic [TRC_AW:0] wr_ptr_q, rd_ptr_q;
  logic [7:0]      ovf_q;

  logic       sel_vec, sel_ram, sel_rom;
  logic [7:0] rd_data, bus_byte;
  logic       empty, full, push, pop, drop;

  // Address decode in priority order: vector, RAM, ROM, open bus.
  always_comb begin
    sel_vec = VEC_OVR && (Addr_bus == 16'hFFFC || Addr_bus == 16'hFFFD);
    sel_ram = !sel_vec && (Addr_bus <= RAM_TOP);
    sel_rom = !sel_vec && !sel_ram && (Addr_bus >= ROM_BASE);
    if (sel_vec) begin
      rd_data = Addr_bus[0] ? RST_VEC[15:8] : RST_VEC[7:0];
    end else if (sel_ram) begin
      rd_data = ram[Addr_bus[RAM_AW-1:0]];
    end else if (sel_rom) begin
      rd_data = rom[Addr_bus[ROM_AW-1:0]];
    end else begin
      rd_data = ob_q;
    end
    bus_byte = R_nW ? rd_data : Data_bus_out;
  end

  assign Data_bus_in = rd_data;

  always_ff @(posedge clk_ph2) begin
    if (!R_nW && sel_ram) begin
      ram[Addr_bus[RAM_AW-1:0]] <= Data_bus_out;
    end
  end

  always_ff @(posedge clk_ph2) begin
    if (prog_we) begin
      rom[prog_addr] <= prog_data;
    end
  end

  always_ff @(posedge clk_ph2 or negedge rst) begin
    if (!rst) begin
      ob_q         <= 8'h00;
      rom_wr_err_q <= 1'b0;
    end else begin
      ob_q <= bus_byte;
      if (!R_nW && sel_rom) begin
        rom_wr_err_q <= 1'b1;
      end
    end
  end

  assign rom_wr_err = rom_wr_err_q;

  // Trace FIFO: a pop on a full FIFO frees the slot the same-cycle push lands in.
  always_comb begin
    empty = (wr_ptr_q == rd_ptr_q);
    full  = (wr_ptr_q[TRC_AW] != rd_ptr_q[TRC_AW]) &&
            (wr_ptr_q[TRC_AW-1:0] == rd_ptr_q[TRC_AW-1:0]);
    pop   = trc_rd && !empty;
    push  = trc_en && (!full || pop);
    drop  = trc_en && full && !pop;
  end

  always_ff @(posedge clk_ph2) begin
    if (push) begin
      trc_mem[wr_ptr_q[TRC_AW-1:0]] <= {R_nW, Addr_bus, bus_byte};
    end
  end

  always_ff @(posedge clk_ph2 or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 8'h00;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrOne;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrOne;
      end
      if (drop && ovf_q != 8'hFF) begin
        ovf_q <= ovf_q + 8'd1;
      end
    end
  end

  assign trc_valid   = !empty;
  assign trc_data    = empty ? 25'd0 : trc_mem[rd_ptr_q[TRC_AW-1:0]];
  assign trc_ovf_cnt = ovf_q;

endmodule

// File: tb/tb_cpu_bus_mem.sv
// Bench for cpu_bus_mem: directed scenarios then random CPU traffic, all checked against an
// address-arithmetic memory model and a queue-based trace model.
module tb_cpu_bus_mem;

  logic        clk_ph2 = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] Addr_bus;
  logic [7:0]  Data_bus_out;
  logic        R_nW;
  logic [7:0]  Data_bus_in;
  logic        prog_we;
  logic [14:0] prog_addr;
  logic [7:0]  prog_data;
  logic        trc_en;
  logic        trc_rd;
  logic        trc_valid;
  logic [24:0] trc_data;
  logic [7:0]  trc_ovf_cnt;
  logic        rom_wr_err;

  cpu_bus_mem #(
    .RAM_AW  (11),
    .RAM_TOP (16'h1FFF),
    .ROM_BASE(16'h8000),
    .ROM_AW  (15),
    .VEC_OVR (1'b1),
    .RST_VEC (16'hC123),
    .TRC_AW  (4)
  ) dut (
    .clk_ph2     (clk_ph2),
    .rst         (rst),
    .Addr_bus    (Addr_bus),
    .Data_bus_out(Data_bus_out),
    .R_nW        (R_nW),
    .Data_bus_in (Data_bus_in),
    .prog_we     (prog_we),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .trc_en      (trc_en),
    .trc_rd      (trc_rd),
    .trc_valid   (trc_valid),
    .trc_data    (trc_data),
    .trc_ovf_cnt (trc_ovf_cnt),
    .rom_wr_err  (rom_wr_err)
  );

  always #5 clk_ph2 = ~clk_ph2;

  // Reference model state
  logic [7:0]  ram_m [2048];
  bit          ram_k [2048];
  logic [7:0]  rom_m [32768];
  bit          rom_k [32768];
  int          known_ram[$];
  int          known_rom[$];
  logic [24:0] q[$];
  int          ovf_m = 0;
  bit          err_m = 1'b0;
  logic [7:0]  ob_m = 8'h00;

  logic        pw = 1'b0;
  logic [14:0] pa = '0;
  logic [7:0]  pd = '0;

  int n_checks = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [7:0] model_read(input logic [15:0] a);
    int ai;
    ai = int'(a);
    if (ai == 32'hFFFC) return 8'h23;
    if (ai == 32'hFFFD) return 8'hC1;
    if (ai < 32'h2000) return ram_m[ai % 2048];
    if (ai >= 32'h8000) return rom_m[ai - 32'h8000];
    return ob_m;
  endfunction

  // One bus cycle: drive, check pre-edge outputs, clock, advance the model.
  task automatic step(input bit rnw, input logic [15:0] a, input logic [7:0] wd,
                      input bit en, input bit rd);
    logic [7:0] exp_rd, bus;
    int ai;
    R_nW = rnw; Addr_bus = a; Data_bus_out = wd; trc_en = en; trc_rd = rd;
    prog_we = pw; prog_addr = pa; prog_data = pd;
    #2;
    exp_rd = model_read(a);
    if (rnw) chk("rdata", {24'd0, Data_bus_in}, {24'd0, exp_rd});
    chk("trc_valid", {31'd0, trc_valid}, {31'd0, q.size() != 0});
    chk("trc_data", {7'd0, trc_data}, (q.size() != 0) ? {7'd0, q[0]} : 32'd0);
    chk("trc_ovf_cnt", {24'd0, trc_ovf_cnt}, ovf_m);
    chk("rom_wr_err", {31'd0, rom_wr_err}, {31'd0, err_m});
    bus = rnw ? exp_rd : wd;
    @(posedge clk_ph2);
    if (rd && q.size() != 0) void'(q.pop_front());
    if (en) begin
      if (q.size() < 16) q.push_back({rnw, a, bus});
      else if (ovf_m < 255) ovf_m++;
    end
    ob_m = bus;
    ai = int'(a);
    if (!rnw) begin
      if (ai <= 32'h1FFF) begin
        ram_m[ai % 2048] = wd;
        if (!ram_k[ai % 2048]) begin
          ram_k[ai % 2048] = 1'b1;
          known_ram.push_back(ai % 2048);
        end
      end else if (ai >= 32'h8000 && ai != 32'hFFFC && ai != 32'hFFFD) begin
        err_m = 1'b1;
      end
    end
    if (pw) begin
      rom_m[int'(pa)] = pd;
      if (!rom_k[int'(pa)]) begin
        rom_k[int'(pa)] = 1'b1;
        known_rom.push_back(int'(pa));
      end
    end
    pw = 1'b0;
    #1;
  endtask

  initial begin
    int op, idx;
    logic [15:0] a;
    R_nW = 1'b1; Addr_bus = 16'h5000; Data_bus_out = 8'h00; trc_en = 1'b0; trc_rd = 1'b0;
    prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    #1 rst = 1'b0;
    #1;
    chk("reset_valid", {31'd0, trc_valid}, 32'd0);
    chk("reset_data", {7'd0, trc_data}, 32'd0);
    chk("reset_ovf", {24'd0, trc_ovf_cnt}, 32'd0);
    chk("reset_err", {31'd0, rom_wr_err}, 32'd0);
    repeat (2) @(posedge clk_ph2);
    #1 rst = 1'b1;

    // Open bus after reset, then mirroring
    step(1'b1, 16'h5000, 8'h00, 1'b0, 1'b0);
    step(1'b0, 16'h0005, 8'hAA, 1'b0, 1'b0);
    step(1'b1, 16'h0805, 8'h00, 1'b0, 1'b0);
    step(1'b1, 16'h1805, 8'h00, 1'b0, 1'b0);
    step(1'b1, 16'h0005, 8'h00, 1'b0, 1'b0);
    step(1'b1, 16'h5000, 8'h00, 1'b0, 1'b0);
    chk("open_bus_aa", {24'd0, Data_bus_in}, 32'hAA);
    // ROM load, read, write attempt
    pw = 1'b1; pa = 15'h0000; pd = 8'hA2;
    step(1'b1, 16'h5000, 8'h00, 1'b0, 1'b0);
    step(1'b1, 16'h8000, 8'h00, 1'b0, 1'b0);
    step(1'b0, 16'h8000, 8'h55, 1'b0, 1'b0);
    step(1'b1, 16'h8000, 8'h00, 1'b0, 1'b0);
    chk("rom_wr_err_set", {31'd0, rom_wr_err}, 32'd1);
    // Vector override regardless of ROM contents
    pw = 1'b1; pa = 15'h7FFC; pd = 8'h99;
    step(1'b1, 16'h5000, 8'h00, 1'b0, 1'b0);
    pw = 1'b1; pa = 15'h7FFD; pd = 8'h66;
    step(1'b1, 16'hFFFC, 8'h00, 1'b0, 1'b0);
    step(1'b1, 16'hFFFD, 8'h00, 1'b0, 1'b0);

    // Trace: 19 pushes, no pops
    for (int i = 0; i < 19; i++)
      step(i[0], i[0] ? 16'h0805 : 16'(32'h4000 + i), 8'(i * 7), 1'b1, 1'b0);
    chk("ovf_after_19", {24'd0, trc_ovf_cnt}, 32'd3);
    for (int i = 0; i < 16; i++) step(1'b1, 16'h5000, 8'h00, 1'b0, 1'b1);
    chk("drained", {31'd0, trc_valid}, 32'd0);
    for (int i = 0; i < 16; i++) step(1'b0, 16'(32'h3000 + i), 8'(i), 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 16'h0005, 8'h00, 1'b1, 1'b1);
    chk("full_push_pop_no_ovf", {24'd0, trc_ovf_cnt}, 32'd3);
    for (int i = 0; i < 260; i++) step(1'b1, 16'h1805, 8'h00, 1'b1, 1'b0);
    chk("ovf_saturated", {24'd0, trc_ovf_cnt}, 32'd255);
    for (int i = 0; i < 16; i++) step(1'b1, 16'h5000, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 16'h6000, 8'(8'h10 + i), 1'b1, 1'b0);

    // Reset mid-run with 5 entries queued
    chk("pre_reset_valid", {31'd0, trc_valid}, 32'd1);
    rst = 1'b0;
    #1;
    chk("rst_mid_valid", {31'd0, trc_valid}, 32'd0);
    chk("rst_mid_ovf", {24'd0, trc_ovf_cnt}, 32'd0);
    chk("rst_mid_err", {31'd0, rom_wr_err}, 32'd0);
    R_nW = 1'b1; Addr_bus = 16'h0005;
    #1;
    chk("ram_survives_reset", {24'd0, Data_bus_in}, 32'hAA);
    q.delete(); ovf_m = 0; err_m = 1'b0; ob_m = 8'h00;
    rst = 1'b1;
    step(1'b1, 16'h5000, 8'h00, 1'b0, 1'b0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      op = $urandom_range(0, 5);
      if ($urandom_range(0, 3) == 0) begin
        pw = 1'b1; pa = 15'($urandom_range(0, 32767)); pd = 8'($urandom);
      end
      case (op)
        0: begin
          idx = known_ram[$urandom_range(0, known_ram.size() - 1)];
          a = 16'(idx + 2048 * $urandom_range(0, 3));
          step(1'b1, a, 8'h00, 1'($urandom), 1'($urandom));
        end
        1: begin
          idx = known_rom[$urandom_range(0, known_rom.size() - 1)];
          step(1'b1, 16'(32'h8000 + idx), 8'h00, 1'($urandom), 1'($urandom));
        end
        2: step(1'b1, 16'($urandom_range(32'h2000, 32'h7FFF)), 8'h00, 1'($urandom),
                1'($urandom));
        3: step(1'b1, 16'(32'hFFFC + $urandom_range(0, 1)), 8'h00, 1'($urandom), 1'($urandom));
        4: step(1'b0, 16'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
        default: step(1'b0, 16'($urandom_range(0, 32'h1FFF)), 8'($urandom), 1'($urandom),
                      1'($urandom));
      endcase
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
